ibex_mem_arbiter: RTL and testbench
===================================

Name: ibex_mem_arbiter

Overview:
- Shares one single-port SRAM (1-cycle read latency, always ready) between the Ibex instruction-fetch port and data port.
- Replaces the ad-hoc combinational arbiter and registered gnt in the top level.
- Grants in the request cycle, routes the response back to the owning port one cycle later, and flags out-of-range accesses with an error response.
- Prevents data-port starvation with a bounded instruction-priority streak.

Parameters:
- MEM_START, 32'h0000_0000, byte base address of the SRAM window.
- MEM_SIZE, 8192, window size in bytes; power of two, ≥ 4.
- MAX_INSTR_STREAK, 4, consecutive instruction grants allowed while data_req_i is pending; range 1..15.

Ports:
- clk_sys  in  1  system clock
- rst_sys  in  1  reset, asynchronous, active-high
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch grant (combinational)
- instr_rvalid_o  out  1  fetch response valid
- instr_err_o  out  1  fetch out-of-range error, valid with rvalid
- instr_rdata_o  out  32  fetch read data
- data_req_i  in  1  data request
- data_we_i  in  1  data write enable
- data_be_i  in  4  data byte enables
- data_addr_i  in  32  data byte address
- data_wdata_i  in  32  data write data
- data_gnt_o  out  1  data grant (combinational)
- data_rvalid_o  out  1  data response valid (reads and writes)
- data_err_o  out  1  data out-of-range error
- data_rdata_o  out  32  data read data
- mem_req_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write enable
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  32  SRAM byte address, unmasked
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, valid one cycle after mem_req_o

Behaviour:
- Clocking and reset: one clock (clk_sys). Reset rst_sys is asynchronous and active-high.
  - Reset clears rvalid_q, err_q, owner_q=NONE and streak_q=0.
  - Consequently, during and directly after reset, both rvalid outputs, both err outputs, both rdata outputs, and all mem_* outputs are 0 when no request is present.
  - A response pending when reset asserts is dropped and is never delivered.
- Arbitration (combinational, every cycle):
  - Only data_req_i pending: data wins.
  - Only instr_req_i pending: instr wins.
  - Both pending: instr wins unless streak_q == MAX_INSTR_STREAK, in which case data wins.
- Grants:
  - Exactly one grant per cycle at most; gnt is asserted in the same cycle as the winning request.
  - The loser's gnt is 0, and the loser must hold its request.
- In-range check: (addr & ~(MEM_SIZE-1)) == MEM_START.
- Granted access, in range:
  - mem_req_o=1 and the mem_* outputs carry the winner's fields.
  - For an instr winner, mem_we_o=0 and mem_be_o=4'hF.
- Granted access, out of range:
  - mem_req_o=0 and all mem_* outputs are 0.
  - The error is registered for the response.
- No grant: all mem_* outputs are 0.
- Response tracking:
  - Registers: owner_q ∈ {NONE, INSTR, DATA}, err_q, rvalid_q; loaded on every cycle with a grant, otherwise owner_q=NONE.
  - Latency is exactly 1 cycle from grant to rvalid, for reads and writes, in range or erroring.
  - {port}_rvalid_o = (owner_q == port).
  - {port}_err_o = rvalid & err_q.
  - {port}_rdata_o = mem_rdata_i when rvalid & !err_q, else 32'h0.
  - Back-to-back grants are allowed every cycle, and alternating owners route correctly.
- Streak counter (4 bits):
  - Increment on an instr grant while data_req_i=1, saturating at MAX_INSTR_STREAK.
  - Clear on a data grant, or on any cycle with data_req_i=0.
- Write response: data_rvalid_o=1 with data_rdata_o = mem_rdata_i. The content is don't-care, but it must not be X-propagated into err.
- Address wrap: addresses at MEM_START+MEM_SIZE and above, or below MEM_START, produce an error. Address 32'hFFFF_FFFC with MEM_START=0 produces an error.

Decomposition:
- Package ibex_mem_arb_pkg:
  - owner_e enum {OWNER_NONE, OWNER_INSTR, OWNER_DATA}, 2 bits.
  - in_range() function parameterised by start/size.
  - STREAK_W=4 constant.
- Sub-module ibex_mem_arb_resp: holds owner_q/err_q and does rdata/rvalid/err demux. It is natural to isolate it for reuse with a future ROM port.
- The arbiter core and streak counter stay in the top module.

Test Plan:
- Reset: assert rst_sys for 3 cycles while instr_req_i=1, then deassert -> all rvalid/err outputs 0 during reset; first grant in the cycle after release.
- Instruction only: instr_req_i=1, addr 0x80, SRAM word 0x0000_0013 -> instr_gnt_o=1 in cycle N, mem_addr_o=0x80; instr_rvalid_o=1 and instr_rdata_o=0x13 in cycle N+1.
- Data write: data_req_i=1, we=1, be=4'h3, addr 0x100, wdata 0xDEAD_BEEF -> mem_we_o=1, mem_be_o=4'h3 in cycle N; data_rvalid_o=1, data_err_o=0 in cycle N+1; a later read of 0x100 returns 0x0000_BEEF over an initial 0.
- Contention with MAX_INSTR_STREAK=4: instr_req_i and data_req_i held high continuously -> grant pattern I,I,I,I,D,I,I,I,I,D; each response goes to the correct port one cycle later.
- Out of range: data read at 0x0000_2000 (MEM_SIZE=8192) -> data_gnt_o=1, mem_req_o=0; next cycle data_rvalid_o=1, data_err_o=1, data_rdata_o=0.
- Mid-flight reset: grant an instr read in cycle N and assert rst_sys in cycle N+1 before the edge -> instr_rvalid_o stays 0; no response is ever delivered for that read.

Source files
------------

// File: rtl/ibex_mem_arb_pkg.sv
// Shared types and helpers for the Ibex instruction/data SRAM arbiter.
package ibex_mem_arb_pkg;

    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_INSTR = 2'd1,
        OWNER_DATA  = 2'd2
    } owner_e;

    // The window must be size-aligned, so masking off the offset bits yields the base.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] start,
                                      input logic [31:0] size);
        return (addr & ~(size - 32'd1)) == start;
    endfunction

endpackage

// File: rtl/ibex_mem_arb_resp.sv
// Response tracker: remembers who owns the in-flight access and steers rvalid/err/rdata
// back to that port one cycle after the grant.
module ibex_mem_arb_resp
    import ibex_mem_arb_pkg::*;
(
    input  logic        clk_sys,
    input  logic        rst_sys,
    input  logic [1:0]  i_owner,
    input  logic        i_err,
    input  logic [31:0] i_mem_rdata,
    output logic        o_instr_rvalid,
    output logic        o_instr_err,
    output logic [31:0] o_instr_rdata,
    output logic        o_data_rvalid,
    output logic        o_data_err,
    output logic [31:0] o_data_rdata
);

    owner_e      r_owner;
    logic        r_err;
    logic        w_rvalid;
    logic [31:0] w_rdata;

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_owner <= OWNER_NONE;
            r_err   <= 1'b0;
        end else begin
            r_owner <= owner_e'(i_owner);
            r_err   <= i_err;
        end
    end

    // Error responses never expose SRAM data, which may be stale from an earlier access.
    assign w_rvalid = (r_owner != OWNER_NONE);
    assign w_rdata  = (w_rvalid && !r_err) ? i_mem_rdata : 32'h0;

    assign o_instr_rvalid = (r_owner == OWNER_INSTR);
    assign o_instr_err    = o_instr_rvalid & r_err;
    assign o_instr_rdata  = o_instr_rvalid ? w_rdata : 32'h0;

    assign o_data_rvalid  = (r_owner == OWNER_DATA);
    assign o_data_err     = o_data_rvalid & r_err;
    assign o_data_rdata   = o_data_rvalid ? w_rdata : 32'h0;

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Single-port SRAM arbiter between Ibex fetch and data ports: same-cycle grant,
// one-cycle response, out-of-range error, bounded instruction priority.
module ibex_mem_arbiter
    import ibex_mem_arb_pkg::*;
#(
    parameter logic [31:0] MEM_START        = 32'h0000_0000,
    parameter int          MEM_SIZE         = 8192,
    parameter int          MAX_INSTR_STREAK = 4
) (
    input  logic        clk_sys,
    input  logic        rst_sys,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic        instr_err_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic        data_err_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [STREAK_W-1:0] MAX_STREAK = MAX_INSTR_STREAK[STREAK_W-1:0];
    localparam logic [31:0]         SIZE_W     = MEM_SIZE[31:0];

    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_streak_nxt;
    logic                w_instr_gnt;
    logic                w_data_gnt;
    logic [31:0]         w_sel_addr;
    logic                w_in_range;
    logic [1:0]          w_owner;
    logic                w_err;

    // Grants are held off while reset is asserted so the first grant lands after release.
    always_comb begin
        w_instr_gnt = 1'b0;
        w_data_gnt  = 1'b0;
        if (!rst_sys) begin
            if (data_req_i && (!instr_req_i || (r_streak == MAX_STREAK))) begin
                w_data_gnt = 1'b1;
            end else if (instr_req_i) begin
                w_instr_gnt = 1'b1;
            end
        end
    end

    assign w_sel_addr = w_data_gnt ? data_addr_i : instr_addr_i;
    assign w_in_range = in_range(w_sel_addr, MEM_START, SIZE_W);

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        w_owner     = OWNER_NONE;
        w_err       = 1'b0;
        if (w_data_gnt || w_instr_gnt) begin
            w_owner = w_data_gnt ? OWNER_DATA : OWNER_INSTR;
            w_err   = !w_in_range;
            if (w_in_range) begin
                mem_req_o   = 1'b1;
                mem_we_o    = w_data_gnt & data_we_i;
                mem_be_o    = w_data_gnt ? data_be_i : 4'hF;
                mem_addr_o  = w_sel_addr;
                mem_wdata_o = w_data_gnt ? data_wdata_i : 32'h0;
            end
        end
    end

    // Streak only counts instruction wins that actually made the data port wait.
    always_comb begin
        w_streak_nxt = r_streak;
        if (w_data_gnt || !data_req_i) begin
            w_streak_nxt = '0;
        end else if (w_instr_gnt && (r_streak != MAX_STREAK)) begin
            w_streak_nxt = r_streak + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_streak <= '0;
        end else begin
            r_streak <= w_streak_nxt;
        end
    end

    assign instr_gnt_o = w_instr_gnt;
    assign data_gnt_o  = w_data_gnt;

    ibex_mem_arb_resp u_resp (
        .clk_sys        (clk_sys),
        .rst_sys        (rst_sys),
        .i_owner        (w_owner),
        .i_err          (w_err),
        .i_mem_rdata    (mem_rdata_i),
        .o_instr_rvalid (instr_rvalid_o),
        .o_instr_err    (instr_err_o),
        .o_instr_rdata  (instr_rdata_o),
        .o_data_rvalid  (data_rvalid_o),
        .o_data_err     (data_err_o),
        .o_data_rdata   (data_rdata_o)
    );

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Bench for ibex_mem_arbiter: directed vector table, contention and reset sequences,
// then randomized traffic against a reference model.
module tb_ibex_mem_arbiter;

    localparam int MAX_STREAK = 4;
    localparam int MEM_BYTES  = 8192;

    logic        clk_sys;
    logic        rst_sys;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic        instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    ibex_mem_arbiter #(
        .MEM_START        (32'h0000_0000),
        .MEM_SIZE         (MEM_BYTES),
        .MAX_INSTR_STREAK (MAX_STREAK)
    ) dut (
        .clk_sys        (clk_sys),
        .rst_sys        (rst_sys),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_err_o    (instr_err_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_err_o     (data_err_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    // ---------------- clock ----------------
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // ---------------- SRAM model (1-cycle read latency) ----------------
    logic [31:0] sram [0:2047];
    logic        sram_clear;

    always @(posedge clk_sys) begin
        if (sram_clear) begin
            for (int i = 0; i < 2048; i++) sram[i] <= 32'h0;
        end else if (mem_req_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_we_o && mem_be_o[b])
                    sram[mem_addr_o[12:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            mem_rdata_i <= sram[mem_addr_o[12:2]];
        end
    end

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] ref_mem [0:2047];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive_idle();
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
    endtask

    function automatic logic model_in_range(input logic [31:0] a);
        return ({32'h0, a} < 64'(MEM_BYTES));
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8)       return 32'($urandom_range(0, 2047)) << 2;
        else if (r == 8) return 32'h2000 + (32'($urandom_range(0, 1023)) << 2);
        else             return 32'hFFFF_FFFC;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        eig;
        logic        edg;
        logic        emreq;
        logic [31:0] emaddr;
        logic        emwe;
        logic [3:0]  embe;
        logic        eerr;
        logic        erd_chk;
        logic [31:0] erdata;
        string       name;
    } vec_t;

    vec_t vecs [9];

    // random-phase model state
    int          run;
    logic        ipend, dpend, dwe_r;
    logic [3:0]  dbe_r;
    logic [31:0] iaddr_r, daddr_r, dwdata_r;
    logic        exp_v, exp_port_d, exp_err, exp_rd;
    logic [31:0] exp_data;

    task automatic check_rsp(input string tag);
        chk({tag, "_irv"}, 32'(instr_rvalid_o), 32'(exp_v && !exp_port_d));
        chk({tag, "_drv"}, 32'(data_rvalid_o),  32'(exp_v && exp_port_d));
        chk({tag, "_ierr"}, 32'(instr_err_o), 32'(exp_v && !exp_port_d && exp_err));
        chk({tag, "_derr"}, 32'(data_err_o),  32'(exp_v && exp_port_d && exp_err));
        if (exp_v && (exp_rd || exp_err))
            chk({tag, "_rdata"}, exp_port_d ? data_rdata_o : instr_rdata_o,
                exp_err ? 32'h0 : exp_data);
    endtask

    initial begin
        drive_idle();
        rst_sys    = 1'b0;
        sram_clear = 1'b1;
        for (int i = 0; i < 2048; i++) ref_mem[i] = 32'h0;

        vecs[0] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h80, 32'h13,
                    1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 4'hF, 1'b0, 1'b0, 32'h0, "wr80"};
        vecs[1] = '{1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 4'hF, 1'b0, 1'b1, 32'h13, "if80"};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF,
                    1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 4'h3, 1'b0, 1'b0, 32'h0, "wr100"};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0,
                    1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 4'hF, 1'b0, 1'b1, 32'h0000_BEEF, "rd100"};
        vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0,
                    1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1, 32'h0, "rd2000"};
        vecs[5] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1, 32'h0, "ifFFFC"};
        vecs[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h1FFC, 32'h0,
                    1'b0, 1'b1, 1'b1, 32'h1FFC, 1'b0, 4'hF, 1'b0, 1'b1, 32'h0, "rd1FFC"};
        vecs[7] = '{1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0,
                    1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 4'hF, 1'b0, 1'b1, 32'h13, "both"};
        vecs[8] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0, "idle"};

        // ---- reset with a fetch request held high ----
        #1;
        rst_sys      = 1'b1;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0;
        repeat (3) begin
            @(posedge clk_sys);
            #3;
            chk("rst_ig nt", 32'(instr_gnt_o), 32'h0);
            chk("rst_memreq", 32'(mem_req_o), 32'h0);
            chk("rst_memaddr", mem_addr_o, 32'h0);
            chk("rst_rvalid", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
            chk("rst_err", {30'h0, instr_err_o, data_err_o}, 32'h0);
            chk("rst_rdata", instr_rdata_o | data_rdata_o, 32'h0);
        end
        sram_clear = 1'b0;
        step();
        rst_sys = 1'b0;
        #2;
        chk("post_rst_gnt", 32'(instr_gnt_o), 32'h1);
        chk("post_rst_memreq", 32'(mem_req_o), 32'h1);
        step();
        drive_idle();
        #2;
        chk("post_rst_rvalid", 32'(instr_rvalid_o), 32'h1);
        chk("post_rst_rdata", instr_rdata_o, 32'h0);
        step();

        // ---- table-driven single accesses ----
        for (int i = 0; i < 9; i++) begin
            instr_req_i  = vecs[i].ireq;
            instr_addr_i = vecs[i].iaddr;
            data_req_i   = vecs[i].dreq;
            data_we_i    = vecs[i].dwe;
            data_be_i    = vecs[i].dbe;
            data_addr_i  = vecs[i].daddr;
            data_wdata_i = vecs[i].dwdata;
            #2;
            chk({vecs[i].name, "_igrant"}, 32'(instr_gnt_o), 32'(vecs[i].eig));
            chk({vecs[i].name, "_dgrant"}, 32'(data_gnt_o), 32'(vecs[i].edg));
            chk({vecs[i].name, "_mreq"}, 32'(mem_req_o), 32'(vecs[i].emreq));
            chk({vecs[i].name, "_maddr"}, mem_addr_o, vecs[i].emaddr);
            chk({vecs[i].name, "_mwe"}, 32'(mem_we_o), 32'(vecs[i].emwe));
            chk({vecs[i].name, "_mbe"}, 32'(mem_be_o), 32'(vecs[i].embe));
            if (vecs[i].edg && vecs[i].emreq && vecs[i].dwe)
                chk({vecs[i].name, "_mwdata"}, mem_wdata_o, vecs[i].dwdata);
            step();
            drive_idle();
            #2;
            exp_v      = vecs[i].eig || vecs[i].edg;
            exp_port_d = vecs[i].edg;
            exp_err    = vecs[i].eerr;
            exp_rd     = vecs[i].erd_chk;
            exp_data   = vecs[i].erdata;
            check_rsp(vecs[i].name);
            step();
        end
        ref_mem[32'h80 >> 2]  = 32'h0000_0013;
        ref_mem[32'h100 >> 2] = 32'h0000_BEEF;

        // ---- sustained contention: I,I,I,I,D repeating ----
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h80;
        data_req_i   = 1'b1;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        data_addr_i  = 32'h100;
        exp_v        = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #2;
            check_rsp("cont");
            chk("cont_igrant", 32'(instr_gnt_o), 32'((k % 5) != 4));
            chk("cont_dgrant", 32'(data_gnt_o),  32'((k % 5) == 4));
            exp_v      = 1'b1;
            exp_port_d = ((k % 5) == 4);
            exp_err    = 1'b0;
            exp_rd     = 1'b1;
            exp_data   = exp_port_d ? 32'h0000_BEEF : 32'h0000_0013;
            step();
        end
        drive_idle();
        #2;
        check_rsp("cont_last");
        step();

        // ---- reset while a fetch response is in flight ----
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h80;
        #2;
        chk("mid_gnt", 32'(instr_gnt_o), 32'h1);
        #1;
        rst_sys = 1'b1;
        drive_idle();
        #1;
        chk("mid_rvalid_a", 32'(instr_rvalid_o), 32'h0);
        step();
        chk("mid_rvalid_b", 32'(instr_rvalid_o), 32'h0);
        step();
        rst_sys = 1'b0;
        repeat (3) begin
            #2;
            chk("mid_rvalid_after", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
            step();
        end

        // ---- randomized traffic with holding masters ----
        run   = 0;
        ipend = 1'b0;
        dpend = 1'b0;
        exp_v = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic        i_w, d_w, inr;
            logic [31:0] a;
            check_rsp("rnd");
            if (!ipend && ($urandom_range(0, 2) != 0)) begin
                ipend   = 1'b1;
                iaddr_r = rand_addr();
            end
            if (!dpend && ($urandom_range(0, 1) != 0)) begin
                dpend    = 1'b1;
                dwe_r    = 1'($urandom_range(0, 1));
                dbe_r    = 4'($urandom_range(1, 15));
                daddr_r  = rand_addr();
                dwdata_r = $urandom;
            end
            instr_req_i  = ipend;
            instr_addr_i = iaddr_r;
            data_req_i   = dpend;
            data_we_i    = dwe_r;
            data_be_i    = dbe_r;
            data_addr_i  = daddr_r;
            data_wdata_i = dwdata_r;
            #2;
            d_w = dpend && (!ipend || (run == MAX_STREAK));
            i_w = ipend && !d_w;
            chk("rnd_igrant", 32'(instr_gnt_o), 32'(i_w));
            chk("rnd_dgrant", 32'(data_gnt_o), 32'(d_w));
            a   = d_w ? daddr_r : iaddr_r;
            inr = model_in_range(a);
            chk("rnd_mreq", 32'(mem_req_o), 32'((i_w || d_w) && inr));
            if ((i_w || d_w) && inr) begin
                chk("rnd_maddr", mem_addr_o, a);
                chk("rnd_mwe", 32'(mem_we_o), 32'(d_w && dwe_r));
                chk("rnd_mbe", 32'(mem_be_o), d_w ? 32'(dbe_r) : 32'hF);
                if (d_w && dwe_r) chk("rnd_mwdata", mem_wdata_o, dwdata_r);
            end
            exp_v      = i_w || d_w;
            exp_port_d = d_w;
            exp_err    = !inr;
            exp_rd     = i_w || !dwe_r;
            exp_data   = inr ? ref_mem[a[12:2]] : 32'h0;
            if (d_w && dwe_r && inr)
                for (int b = 0; b < 4; b++)
                    if (dbe_r[b]) ref_mem[a[12:2]][8*b +: 8] = dwdata_r[8*b +: 8];
            // A waiting data port tolerates at most MAX_STREAK fetch wins in a row.
            if (!dpend || d_w) run = 0;
            else if (i_w && run < MAX_STREAK) run = run + 1;
            if (i_w) ipend = 1'b0;
            if (d_w) dpend = 1'b0;
            step();
        end
        drive_idle();
        #2;
        check_rsp("rnd_last");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
